// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
// Application-side bus of the seven-segment scan driver.
//   value_in    : packed hex nibbles, nibble i = digit i (digit 0 rightmost)
//   dp_in       : decimal point per digit, 1 = lit
//   blank_in    : 1 = digit dark
//   load_in     : single-cycle strobe capturing value/dp/blank into the shadow
//   pending_out : shadow holds data not yet committed to the display
// Modports: master = application logic, slave = driver.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load_in;
  logic                    pending_out;

  modport master (
    output value_in, dp_in, blank_in, load_in,
    input  pending_out
  );

  modport slave (
    input  value_in, dp_in, blank_in, load_in,
    output pending_out
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed common-anode seven-segment driver. Scans NUM_DIGITS digits
// left to right (digit NUM_DIGITS-1 first), SLOT_CYCLES clocks per digit, with
// GUARD_CYCLES of all-anodes-off at the start of each slot. Display data is
// double buffered: load_in fills a shadow register that is committed to the
// active register on the frame boundary, so a frame never mixes old and new data.
// Ports:
//   clk_in        : clock, rising edge
//   rst_in        : synchronous active-high reset
//   bus           : seg7_scan_driver_if.slave (value/dp/blank/load/pending)
//   brightness_in : PWM duty, lit while slot_cnt[3:0] <= brightness_in
//                   (only when SEG7_BRIGHTNESS_EN is defined)
//   frame_out     : one-cycle pulse on the first cycle of each frame
//   anode_out     : active-low one-cold anode select, anode_out[i] = digit i
//   digit_out     : active-low {dp,g,f,e,d,c,b,a}
// All outputs are registered and lag the scan counters by one cycle.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  seg7_scan_driver_if.slave     bus,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [3:0]            brightness_in,
`endif
  output logic                  frame_out,
  output logic [NUM_DIGITS-1:0] anode_out,
  output logic [7:0]            digit_out
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  logic [CW-1:0]           slot_cnt, slot_nxt;
  logic [DW-1:0]           dig, dig_nxt;
  logic [4*NUM_DIGITS-1:0] shadow_val, active_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank, active_blank;
  logic                    pending, pending_nxt;
  logic                    slot_end, frame_end;
  logic                    in_guard, bright_ok, dark;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   one_cold;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic [7:0]              digit_d;
  logic                    frame_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A zero-length guard is elaborated away so no constant compare is built.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (slot_cnt < CW'(GUARD_CYCLES));
    end
  endgenerate

`ifdef SEG7_BRIGHTNESS_EN
  assign bright_ok = (slot_cnt[3:0] <= brightness_in);
`else
  assign bright_ok = 1'b1;
`endif

  assign bus.pending_out = pending;

  // Scan counters and pending flag next-state.
  always_comb begin
    slot_end    = (slot_cnt == SLOT_LAST);
    frame_end   = slot_end && (dig == '0);
    slot_nxt    = slot_end ? '0 : slot_cnt + 1'b1;
    dig_nxt     = dig;
    if (slot_end) begin
      dig_nxt = (dig == '0) ? DIG_LAST : dig - 1'b1;
    end
    // A load on the commit edge re-arms pending for the following frame.
    pending_nxt = pending;
    if (bus.load_in) begin
      pending_nxt = 1'b1;
    end else if (frame_end) begin
      pending_nxt = 1'b0;
    end
  end

  // Output pattern for the slot currently described by slot_cnt/dig.
  always_comb begin
    nibble = active_val[{dig, 2'b00} +: 4];
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      one_cold[i] = (DW'(i) != dig);
    end
    dark    = in_guard || active_blank[dig] || !bright_ok;
    anode_d = '1;
    digit_d = '1;
    if (!dark) begin
      anode_d = one_cold;
      digit_d = {~active_dp[dig], decode(nibble)};
    end
    frame_d = (slot_cnt == '0) && (dig == DIG_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_cnt     <= '0;
      dig          <= DIG_LAST;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      active_val   <= '0;
      active_dp    <= '0;
      active_blank <= '1;
      pending      <= 1'b0;
      anode_out    <= '1;
      digit_out    <= '1;
      frame_out    <= 1'b0;
    end else begin
      slot_cnt  <= slot_nxt;
      dig       <= dig_nxt;
      pending   <= pending_nxt;
      anode_out <= anode_d;
      digit_out <= digit_d;
      frame_out <= frame_d;
      if (frame_end && pending) begin
        active_val   <= shadow_val;
        active_dp    <= shadow_dp;
        active_blank <= shadow_blank;
      end
      if (bus.load_in) begin
        shadow_val   <= bus.value_in;
        shadow_dp    <= bus.dp_in;
        shadow_blank <= bus.blank_in;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SLOT_CYCLES=16,
// GUARD_CYCLES=2 (frame = 64 cycles). Outputs are sampled 1 ns after each
// rising edge; k counts samples since reset release (k=0 is the first frame pulse).
module tb_seg7_scan_driver;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       frame_out;
  logic [3:0] anode_out;
  logic [7:0] digit_out;

  int checks = 0;
  int errors = 0;
  int k = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus_if ();

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .SLOT_CYCLES (16),
    .GUARD_CYCLES(2)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .bus      (bus_if.slave),
    .frame_out(frame_out),
    .anode_out(anode_out),
    .digit_out(digit_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic run_to_frame();
    do tick(); while ((k % 64) != 0);
  endtask

  // seg = {digit3, digit2, digit1, digit0} expected patterns; lit = digits not blanked.
  task automatic check_frame(input string tag, input logic [31:0] seg, input logic [3:0] lit);
    int d;
    int off;
    logic dk;
    logic [3:0] e_an;
    logic [7:0] e_dg;
    for (int s = 0; s < 64; s++) begin
      d    = 3 - s / 16;
      off  = s % 16;
      dk   = (off < 2) || !lit[d];
      e_an = dk ? 4'hF : ~(4'b0001 << d);
      e_dg = dk ? 8'hFF : seg[8*d +: 8];
      chk($sformatf("%s_anode_s%0d", tag, s), {28'd0, anode_out}, {28'd0, e_an});
      chk($sformatf("%s_digit_s%0d", tag, s), {24'd0, digit_out}, {24'd0, e_dg});
      chk($sformatf("%s_frame_s%0d", tag, s), {31'd0, frame_out}, {31'd0, (s == 0)});
      tick();
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus_if.value_in = v;
    bus_if.dp_in    = dp;
    bus_if.blank_in = bl;
    bus_if.load_in  = 1'b1;
    tick();
    bus_if.load_in  = 1'b0;
  endtask

  initial begin
    bus_if.value_in = '0;
    bus_if.dp_in    = '0;
    bus_if.blank_in = '0;
    bus_if.load_in  = 1'b0;

    repeat (3) tick();
    chk("rst_anode",   {28'd0, anode_out}, 32'hF);
    chk("rst_digit",   {24'd0, digit_out}, 32'hFF);
    chk("rst_frame",   {31'd0, frame_out}, 32'd0);
    chk("rst_pending", {31'd0, bus_if.pending_out}, 32'd0);

    rst_in = 1'b0;
    tick();
    k = 0;
    // No load yet: dark for three frames, pulse every 64 cycles.
    check_frame("dark0", 32'd0, 4'h0);
    check_frame("dark1", 32'd0, 4'h0);
    check_frame("dark2", 32'd0, 4'h0);

    // k=192: load 1A3F, dp on digit 1.
    load(16'h1A3F, 4'b0010, 4'b0000);
    chk("pend_rise", {31'd0, bus_if.pending_out}, 32'd1);
    run_to_frame();
    chk("pend_fall", {31'd0, bus_if.pending_out}, 32'd0);
    check_frame("hex", {8'hF9, 8'h88, 8'h30, 8'h8E}, 4'hF);

    // Two loads before the boundary: last one wins.
    repeat (10) tick();
    load(16'h0000, 4'b0000, 4'b0000);
    tick();
    load(16'h8888, 4'b0000, 4'b0000);
    chk("pend_multi", {31'd0, bus_if.pending_out}, 32'd1);
    run_to_frame();
    check_frame("eights", {4{8'h80}}, 4'hF);

    // Load on the commit edge with nothing pending.
    while (k < 510) tick();
    load(16'h5678, 4'b0000, 4'b0000);
    chk("pend_edge0", {31'd0, bus_if.pending_out}, 32'd1);
    tick();
    chk("pend_edge1", {31'd0, bus_if.pending_out}, 32'd1);
    check_frame("eights_hold", {4{8'h80}}, 4'hF);
    chk("pend_edge2", {31'd0, bus_if.pending_out}, 32'd0);
    check_frame("late", {8'h92, 8'h82, 8'hF8, 8'h80}, 4'hF);

    // Blank digits 0 and 2.
    load(16'h1234, 4'b0000, 4'b0101);
    run_to_frame();
    check_frame("blank", {8'hF9, 8'hFF, 8'hB0, 8'hFF}, 4'b1010);

    // Reset mid-slot with pending data: shadow discarded.
    load(16'hFFFF, 4'hF, 4'h0);
    repeat (4) tick();
    chk("pend_prerst", {31'd0, bus_if.pending_out}, 32'd1);
    rst_in = 1'b1;
    tick();
    chk("mid_rst_anode",   {28'd0, anode_out}, 32'hF);
    chk("mid_rst_digit",   {24'd0, digit_out}, 32'hFF);
    chk("mid_rst_frame",   {31'd0, frame_out}, 32'd0);
    chk("mid_rst_pending", {31'd0, bus_if.pending_out}, 32'd0);
    rst_in = 1'b0;
    tick();
    k = 0;
    check_frame("post_rst0", 32'd0, 4'h0);
    check_frame("post_rst1", 32'd0, 4'h0);
    chk("post_rst_pending", {31'd0, bus_if.pending_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
